// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and state encoding for the VGA pixel path
package vga_pkg;

  localparam int PIXEL_W       = 16;
  localparam int MAX_BURST_DEF = 640;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pixel_arbiter.sv
// rtl/pixel_arbiter.sv - round-robin burst arbiter for the VGA pixel FIFO write port
module pixel_arbiter
  import vga_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CW        = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vtrigger,
  input  logic               req0,
  input  logic               req1,
  input  logic               write0,
  input  logic               write1,
  input  logic               last0,
  input  logic               last1,
  input  logic [PIXEL_W-1:0] data0,
  input  logic [PIXEL_W-1:0] data1,
  output logic               grant0,
  output logic               grant1,
  output logic               full0,
  output logic               full1,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [PIXEL_W-1:0] fifo_data,
  output logic               err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          vpend_q, vpend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          own_id, own_req, own_wr, own_last, own_acc, burst_end, sel_ptr;
  logic [CW-1:0] cnt_nx;

  // Shared by IDLE and burst end: lone requester wins, a tie goes to the preferred source.
  function automatic arb_state_e pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1)  return p ? ST_OWN1 : ST_OWN0;
    else if (r0)   return ST_OWN0;
    else if (r1)   return ST_OWN1;
    else           return ST_IDLE;
  endfunction

  assign grant0 = (state_q == ST_OWN0);
  assign grant1 = (state_q == ST_OWN1);
  assign full0  = fifo_full | ~grant0;
  assign full1  = fifo_full | ~grant1;
  assign err    = err_q;

  assign own_id   = grant1;
  assign own_req  = own_id ? req1   : req0;
  assign own_wr   = own_id ? write1 : write0;
  assign own_last = own_id ? last1  : last0;
  assign own_acc  = (grant0 | grant1) & own_wr & ~fifo_full;
  assign cnt_nx   = cnt_q + CW'(1);

  assign fifo_write = own_acc;
  assign fifo_data  = grant1 ? data1 : (grant0 ? data0 : '0);

  assign burst_end = (grant0 | grant1) &
                     ((own_acc & own_last) | (own_acc & (cnt_nx == MAX_C)) | (~own_req & ~own_wr));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vpend_d = vpend_q;
    cnt_d   = cnt_q;
    sel_ptr = ptr_q;
    err_d   = err_q | (write0 & ~grant0) | (write1 & ~grant1);
    case (state_q)
      ST_IDLE: begin
        sel_ptr = vtrigger ? 1'b0 : ptr_q;
        ptr_d   = sel_ptr;
        state_d = pick(req0, req1, sel_ptr);
        cnt_d   = '0;
      end
      default: begin
        if (burst_end) begin
          // A frame start seen during the burst hands the next grant preference to the renderer.
          sel_ptr = (vpend_q | vtrigger) ? 1'b0 : ~own_id;
          ptr_d   = sel_ptr;
          vpend_d = 1'b0;
          state_d = pick(req0, req1, sel_ptr);
          cnt_d   = '0;
        end else begin
          vpend_d = vpend_q | vtrigger;
          cnt_d   = own_acc ? cnt_nx : cnt_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      vpend_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vpend_q <= vpend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pixel_arbiter.sv
// tb/tb_pixel_arbiter.sv - directed self-checking bench for pixel_arbiter
module tb_pixel_arbiter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset, vtrigger, req0, req1, write0, write1, last0, last1, fifo_full;
  logic [15:0] data0, data1, fifo_data;
  logic grant0, grant1, full0, full1, fifo_write, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_arbiter #(.MAX_BURST(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .vtrigger(vtrigger),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .last0(last0), .last1(last1), .data0(data0), .data1(data1),
    .grant0(grant0), .grant1(grant1), .full0(full0), .full1(full1),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data(fifo_data), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert (!(grant0 & grant1)) else begin
        errors++;
        $error("FAIL mutex observed %b%b expected not both", grant0, grant1);
      end
    end
  end

  initial begin
    reset = 1'b0; vtrigger = 1'b0; fifo_full = 1'b0;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    last0 = 1'b0; last1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(posedge clk);
    #1; settle();
    chk("rst_grant0", grant0, 0);
    chk("rst_grant1", grant1, 0);
    chk("rst_full0", full0, 1);
    chk("rst_full1", full1, 1);
    chk("rst_fifo_write", fifo_write, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    next_cyc();

    // single source burst of four pixels
    req0 = 1; settle();
    chk("t1_grant0_lat", grant0, 0);
    next_cyc();
    write0 = 1; data0 = 16'h1111; settle();
    chk("t1_grant0", grant0, 1);
    chk("t1_full0", full0, 0);
    chk("t1_full1", full1, 1);
    chk("t1_wr", fifo_write, 1);
    chk("t1_d1", fifo_data, 16'h1111);
    next_cyc();
    data0 = 16'h2222; settle(); chk("t1_d2", fifo_data, 16'h2222);
    next_cyc();
    data0 = 16'h3333; settle(); chk("t1_d3", fifo_data, 16'h3333);
    next_cyc();
    data0 = 16'h4444; last0 = 1; req0 = 0; settle();
    chk("t1_d4", fifo_data, 16'h4444);
    chk("t1_wr4", fifo_write, 1);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t1_grant0_off", grant0, 0);
    chk("t1_wr_off", fifo_write, 0);
    chk("t1_ptr", dut.ptr_q, 1);
    next_cyc();

    // contention from IDLE, ptr reset to 0 by vtrigger
    vtrigger = 1; req0 = 1; req1 = 1; settle();
    chk("t2_idle", grant0, 0);
    next_cyc();
    vtrigger = 0; write0 = 1; data0 = 16'hA001; settle();
    chk("t2_g0", grant0, 1);
    chk("t2_g1", grant1, 0);
    next_cyc();
    data0 = 16'hA002; last0 = 1; settle();
    chk("t2_dA2", fifo_data, 16'hA002);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t2_hand_g0", grant0, 0);
    chk("t2_hand_g1", grant1, 1);
    chk("t2_ptr1", dut.ptr_q, 1);
    write1 = 1; data1 = 16'hB001; last1 = 1; req1 = 0; #1;
    chk("t2_dB1", fifo_data, 16'hB001);
    next_cyc();
    write1 = 0; last1 = 0; settle();
    chk("t2_back_g1", grant1, 0);
    chk("t2_back_g0", grant0, 1);
    chk("t2_ptr0", dut.ptr_q, 0);
    write0 = 1; data0 = 16'hA003; last0 = 1; req0 = 0; #1;
    chk("t2_dA3", fifo_data, 16'hA003);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t2_end_g0", grant0, 0);
    chk("t2_ptr1b", dut.ptr_q, 1);
    next_cyc();

    // backpressure mid-burst
    req0 = 1; settle(); next_cyc();
    write0 = 1; data0 = 16'hC001; settle();
    chk("t3_wr1", fifo_write, 1);
    next_cyc();
    data0 = 16'hC002; fifo_full = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_stall_wr", fifo_write, 0);
      chk("t3_stall_full0", full0, 1);
      chk("t3_stall_grant", grant0, 1);
      chk("t3_stall_cnt", dut.cnt_q, 1);
      next_cyc();
    end
    fifo_full = 0; settle();
    chk("t3_resume_wr", fifo_write, 1);
    chk("t3_resume_d", fifo_data, 16'hC002);
    next_cyc();
    data0 = 16'hC003; last0 = 1; req0 = 0; settle();
    chk("t3_cnt2", dut.cnt_q, 2);
    chk("t3_d3", fifo_data, 16'hC003);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t3_end", grant0, 0);
    next_cyc();

    // forced end at MAX_BURST=8, then re-grant
    req1 = 1; settle(); next_cyc();
    for (int i = 1; i <= 8; i++) begin
      write1 = 1; data1 = 16'hD000 + 16'(i);
      if (i == 5) req0 = 1;
      settle();
      chk("t4_d", fifo_data, 16'hD000 + 32'(i));
      chk("t4_g1", grant1, 1);
      next_cyc();
    end
    write1 = 0; settle();
    chk("t4_cut_g1", grant1, 0);
    chk("t4_cut_g0", grant0, 1);
    chk("t4_full1", full1, 1);
    write0 = 1; data0 = 16'hE001; last0 = 1; req0 = 0; #1;
    chk("t4_dE1", fifo_data, 16'hE001);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t4_regrant_g1", grant1, 1);
    chk("t4_regrant_g0", grant0, 0);
    for (int i = 9; i <= 12; i++) begin
      write1 = 1; data1 = 16'hD000 + 16'(i);
      last1 = (i == 12); req1 = (i != 12);
      #1;
      chk("t4_d_tail", fifo_data, 16'hD000 + 32'(i));
      next_cyc();
      settle();
    end
    write1 = 0; last1 = 0; #1;
    chk("t4_end_g1", grant1, 0);
    chk("t4_err", err, 0);
    next_cyc();

    // vtrigger during an OWN0 burst with req1 pending: ptr forced to 0
    req0 = 1; settle(); next_cyc();
    write0 = 1; data0 = 16'h6001; vtrigger = 1; req1 = 1; settle();
    chk("t5_dG1", fifo_data, 16'h6001);
    next_cyc();
    vtrigger = 0; data0 = 16'h6002; last0 = 1; settle();
    chk("t5_vpend", dut.vpend_q, 1);
    next_cyc();
    data0 = 16'h6003; req0 = 0; settle();
    chk("t5_g0_again", grant0, 1);
    chk("t5_g1_wait", grant1, 0);
    chk("t5_ptr0", dut.ptr_q, 0);
    chk("t5_vpend_clr", dut.vpend_q, 0);
    chk("t5_dG3", fifo_data, 16'h6003);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t5_own1", grant1, 1);
    write1 = 1; data1 = 16'h7001; vtrigger = 1; req0 = 1; #1;
    chk("t5_dH1", fifo_data, 16'h7001);
    next_cyc();
    vtrigger = 0; data1 = 16'h7002; last1 = 1; req1 = 0; settle();
    chk("t5_vpend1", dut.vpend_q, 1);
    next_cyc();
    write1 = 0; last1 = 0; settle();
    chk("t5_own0", grant0, 1);
    chk("t5_ptr0b", dut.ptr_q, 0);
    write1 = 1; data1 = 16'hDEAD; data0 = 16'h0000; #1;
    chk("t5_ung_wr", fifo_write, 0);
    chk("t5_ung_data", fifo_data, 16'h0000);
    next_cyc();
    write1 = 0; settle();
    chk("t5_err", err, 1);
    write0 = 1; data0 = 16'h8001; last0 = 1; req0 = 0; #1;
    chk("t5_wrI", fifo_write, 1);
    next_cyc();
    write0 = 0; last0 = 0; settle();
    chk("t5_idle", grant0, 0);
    chk("t5_err_sticky", err, 1);
    next_cyc();

    // asynchronous reset mid-burst
    req0 = 1; settle(); next_cyc();
    write0 = 1; data0 = 16'h9001; settle();
    chk("t6_wr", fifo_write, 1);
    reset = 0; #1;
    chk("t6_g0", grant0, 0);
    chk("t6_wr_off", fifo_write, 0);
    chk("t6_full0", full0, 1);
    chk("t6_err", err, 0);
    req0 = 0; write0 = 0;
    next_cyc();
    reset = 1; settle();
    chk("t6_post_g0", grant0, 0);
    chk("t6_post_g1", grant1, 0);
    chk("t6_post_ptr", dut.ptr_q, 0);
    next_cyc();
    settle();
    chk("t6_idle_g0", grant0, 0);
    chk("t6_idle_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter.md
# pixel_arbiter

Shares the single VGA pixel FIFO write port between two pixel sources: source 0 is the line renderer, source 1 is a second generator such as text or a sprite. Each source requests a burst and writes pixels, and the arbiter grants whole bursts round-robin. It routes the granted source's data onto `fifo_write`/`fifo_data` and returns per-source stall signals with the same meaning as `fifo_full`. It sits in the `clk` domain, between the pixel sources and the `vga` block's FIFO inputs.

## Interface
- `MAX_BURST`, default 640: maximum pixels accepted per grant before the burst is forcibly ended.
- `CW`, default 10: burst counter width; must satisfy 2^CW > MAX_BURST.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `vtrigger`  in  1  frame-start pulse from `vga`, one cycle wide.
- `req0` / `req1`  in  1  source requests a burst; held high until its last pixel is accepted.
- `write0` / `write1`  in  1  source presents a pixel this cycle.
- `last0` / `last1`  in  1  qualifies `writeN`; this pixel ends the burst.
- `data0` / `data1`  in  16  RGB565 pixel.
- `grant0` / `grant1`  out  1  source owns the FIFO port; registered.
- `full0` / `full1`  out  1  stall to source: `fifo_full | ~grantN`.
- `fifo_full`  in  1  FIFO full flag from `vga`.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_data`  out  16  FIFO write data.
- `err`  out  1  sticky flag: an ungranted source wrote; cleared only by reset.

## Operation
- States:
  - IDLE: no grant.
  - OWN0: source 0 granted.
  - OWN1: source 1 granted.
- `ptr` (1 bit) marks the preferred source. It resets to 0.
- IDLE:
  - If exactly one `reqN` is high, go to OWNN.
  - If both are high, go to OWN`ptr`.
  - If neither is high, stay in IDLE.
- Accepted pixel in OWNN: `writeN & ~fifo_full`. `fifo_write` equals this term. `fifo_data = dataN`.
- A write from a source with `grantN=0` never reaches the FIFO. It sets `err`.
- The burst counter `cnt` clears on entry to OWNN and increments on each accepted pixel.
- A burst ends in OWNN on any of these:
  - an accepted pixel with `lastN`;
  - an accepted pixel that makes `cnt == MAX_BURST`;
  - `reqN` dropping while no write is pending.
- At burst end `ptr` becomes the other source. The next state is then chosen the same way as from IDLE, using the new `ptr` and the current `req`. This allows a direct OWN0→OWN1 hand-over with no idle cycle.
- `vtrigger`:
  - In IDLE, it sets `ptr` to 0, so the line renderer gets first pixel of the frame.
  - In OWNx, it is latched into `vpend`. At burst end `ptr` is forced to 0 instead of toggling, then `vpend` clears.
- A forced end at MAX_BURST does not notify the source. The source must see `fullN` rise and keep its request up to be re-granted.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `vpend`=0, `cnt`=0, `err`=0;
  - `grant0`=`grant1`=0;
  - `fifo_write`=0, with `fifo_data` don't-care (drive 0).
  - `full0`=`full1`=1, because the grants are 0.
- Grant latency: `reqN` high in cycle t (IDLE) gives `grantN`=1 in cycle t+1. The first pixel can be accepted in t+1.
- Data path latency: 0 cycles. `fifo_write`, `fifo_data` and `fullN` are combinational from the registered state, the source inputs and `fifo_full`.
- Burst end on cycle t: `grantN` drops at t+1. The other source's grant, if pending, rises at t+1.
- At most one grant is ever high; bench asserts `grant0 & grant1` never.
- `fifo_full` high: no pixel accepted, `cnt` holds, grant holds.
- Simultaneous `vtrigger` and burst end: treated as `vpend`=1, so `ptr`=0.
- Reset asserted mid-burst: everything returns to reset values immediately (asynchronously), with no partial write.

## Structure
- Shared package `vga_pkg`:
  - state encoding constants (IDLE, OWN0, OWN1);
  - a `PIXEL_W`=16 constant;
  - the `MAX_BURST` default of 640, matching the active line width.
- Single module; no sub-module. The arbitration is small and flat, and the selection function used from IDLE and at burst end is an internal function.

## Test plan
- Single source: `req0` high, 4 pixels 0x1111..0x4444 with `last0` on the 4th → `grant0` at t+1; `fifo_data` sequence 1111,2222,3333,4444; `grant0`=0 the cycle after.
- Contention: both `req` high from IDLE with `ptr`=0 → OWN0 for its burst, then `grant1` rises in the cycle `grant0` falls; `ptr` alternates over 3 bursts.
- Backpressure: hold `fifo_full`=1 for 5 cycles mid-burst → `fifo_write`=0, `full0`=1, `cnt` frozen; burst resumes without loss.
- MAX_BURST=8, source 1 writes 12 pixels with no `last` → grant drops after the 8th; source 0 (pending) is granted; source 1 is re-granted afterwards for pixels 9–12.
- `vtrigger` during an OWN1 burst, `req0` pending → after the burst `ptr`=0 and OWN0 next; `write1` pulsed while ungranted → `err`=1 and no FIFO write.
- Drive `reset` low mid-burst → grants are 0 and `fifo_write`=0 within the same cycle; after release, state is IDLE and `err`=0.
